// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor scheduler: FSM state encoding,
// opcode and matrix-size encodings, result status codes and a saturating
// increment helper for the error counter.
package coproc_pkg;

  localparam int OP_W   = 3;
  localparam int SIZE_W = 2;
  localparam int NREQ   = 2;

  // Opcode that the coprocessor does not implement; rejected without a launch.
  localparam logic [OP_W-1:0] OP_RESERVED = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_RUN      = 2'd2,
    ST_COMPLETE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'b00,
    STATUS_TIMEOUT = 2'b01,
    STATUS_REJECT  = 2'b10
  } status_e;

  typedef enum logic [SIZE_W-1:0] {
    MSIZE_4X4   = 2'b00,
    MSIZE_8X8   = 2'b01,
    MSIZE_16X16 = 2'b10,
    MSIZE_32X32 = 2'b11
  } msize_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The pointer names the requester that
// wins a tie; it moves to the other requester only when the caller accepts
// the grant, so a request that is never taken does not rotate priority.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
  logic ptr_q, ptr_d;

  // Combinational winner selection; a lone requester always wins.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // Next pointer: after serving requester 0, favour requester 1 and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      ptr_d = gnt_o[0];
    end
  end

  // Pointer register; reset favours requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/coproc_scheduler.sv
// Shares one matrix coprocessor between two requesters. A four-state FSM
// grants the coprocessor, launches it, watches for completion with a
// watchdog, and returns a one-cycle done pulse with a status code.
//
// Handshake: req[i] is a level request from requester i. The scheduler
// acknowledges by raising grant[i] (one-hot), which stays high until the
// cycle after done[i]. Once granted, the operation runs to completion even
// if req[i] drops; op and size are captured at grant time only. done[i] is
// a single-cycle pulse and status is valid in that same cycle.
module coproc_scheduler
  import coproc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [SIZE_W-1:0] req_size0,
  input  logic [SIZE_W-1:0] req_size1,
  output logic [1:0]        grant,
  output logic [OP_W-1:0]   cop_op_code,
  output logic [SIZE_W-1:0] cop_matrix_size,
  output logic              cop_start,
  input  logic              cop_done,
  output logic [1:0]        done,
  output logic [1:0]        status,
  output logic              busy,
  output logic [7:0]        err_cnt,
  output state_e            dbg_state
);

  // Last watchdog value a RUN may reach before being declared timed out.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [OP_W-1:0]   op_q, op_d;
  msize_e            size_q, size_d;
  logic              start_q, start_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        status_q, status_d;
  logic [7:0]        err_q, err_d;
  logic [CNT_W-1:0]  wd_q, wd_d;

  logic [1:0]        arb_gnt;
  logic              arb_accept;

  // Arbitration only matters in IDLE; the pointer moves only when we take it.
  assign arb_accept = (state_q == ST_IDLE) && (req != 2'b00);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req),
    .accept_i (arb_accept),
    .gnt_o    (arb_gnt)
  );

  // Next-state and next-output logic; every register holds by default and
  // the pulse outputs (start, done) default low.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    op_d     = op_q;
    size_d   = size_q;
    start_d  = 1'b0;
    done_d   = 2'b00;
    status_d = status_q;
    err_d    = err_q;
    wd_d     = wd_q;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          grant_d = arb_gnt;
          op_d    = arb_gnt[1] ? req_op1 : req_op0;
          size_d  = msize_e'(arb_gnt[1] ? req_size1 : req_size0);
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (op_q == OP_RESERVED) begin
          status_d = STATUS_REJECT;
          done_d   = grant_q;
          err_d    = sat_inc8(err_q);
          state_d  = ST_COMPLETE;
        end else begin
          start_d = 1'b1;
          wd_d    = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Completion wins over an expiring watchdog in the same cycle.
        if (cop_done) begin
          status_d = STATUS_OK;
          done_d   = grant_q;
          state_d  = ST_COMPLETE;
        end else if (wd_q == WD_LAST) begin
          status_d = STATUS_TIMEOUT;
          done_d   = grant_q;
          err_d    = sat_inc8(err_q);
          state_d  = ST_COMPLETE;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end

      ST_COMPLETE: begin
        // Release the owner; op and size stay on the bus until the next grant.
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end

      default: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides everything, including a RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= 2'b00;
      op_q     <= '0;
      size_q   <= MSIZE_4X4;
      start_q  <= 1'b0;
      done_q   <= 2'b00;
      status_q <= STATUS_OK;
      err_q    <= 8'd0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      op_q     <= op_d;
      size_q   <= size_d;
      start_q  <= start_d;
      done_q   <= done_d;
      status_q <= status_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  assign grant           = grant_q;
  assign cop_op_code     = op_q;
  assign cop_matrix_size = size_q;
  assign cop_start       = start_q;
  assign done            = done_q;
  assign status          = status_q;
  assign busy            = (state_q != ST_IDLE);
  assign err_cnt         = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_coproc_scheduler.sv
// Directed bench for coproc_scheduler with a 16-cycle watchdog. Inputs are
// driven and outputs sampled on the falling edge; the DUT acts on the rising
// edge in between.
module tb_coproc_scheduler;
  import coproc_pkg::*;

  logic              clk;
  logic              reset;
  logic [1:0]        req;
  logic [OP_W-1:0]   req_op0, req_op1;
  logic [SIZE_W-1:0] req_size0, req_size1;
  logic [1:0]        grant;
  logic [OP_W-1:0]   cop_op_code;
  logic [SIZE_W-1:0] cop_matrix_size;
  logic              cop_start;
  logic              cop_done;
  logic [1:0]        done;
  logic [1:0]        status;
  logic              busy;
  logic [7:0]        err_cnt;
  state_e            dbg_state;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  logic [1:0] eg;

  coproc_scheduler #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_op0         (req_op0),
    .req_op1         (req_op1),
    .req_size0       (req_size0),
    .req_size1       (req_size1),
    .grant           (grant),
    .cop_op_code     (cop_op_code),
    .cop_matrix_size (cop_matrix_size),
    .cop_start       (cop_start),
    .cop_done        (cop_done),
    .done            (done),
    .status          (status),
    .busy            (busy),
    .err_cnt         (err_cnt),
    .dbg_state       (dbg_state)
  );

  // Clock and run-time guard.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  // Driver / checker tasks.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req      = 2'b00;
    cop_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; cop_done = 1'b0;
    req_op0 = 3'b000; req_op1 = 3'b000; req_size0 = 2'b00; req_size1 = 2'b00;
    tick();
    tick();
    reset = 1'b0;

    // Reset values.
    chk("rst_grant",  8'(grant), 8'h00);
    chk("rst_start",  8'(cop_start), 8'h00);
    chk("rst_done",   8'(done), 8'h00);
    chk("rst_status", 8'(status), 8'h00);
    chk("rst_busy",   8'(busy), 8'h00);
    chk("rst_err",    err_cnt, 8'h00);
    chk("rst_op",     8'(cop_op_code), 8'h00);
    chk("rst_size",   8'(cop_matrix_size), 8'h00);
    chk("rst_state",  8'(dbg_state), 8'(ST_IDLE));

    // Single request from requester 0, done on the 5th RUN cycle.
    req = 2'b01; req_op0 = 3'b001; req_size0 = 2'b10;
    req_op1 = 3'b110; req_size1 = 2'b11;
    tick();                                   // GRANT
    chk("t1_grant", 8'(grant), 8'h01);
    chk("t1_busy",  8'(busy), 8'h01);
    chk("t1_state_grant", 8'(dbg_state), 8'(ST_GRANT));
    chk("t1_nostart", 8'(cop_start), 8'h00);
    chk("t1_op",    8'(cop_op_code), 8'h01);
    chk("t1_size",  8'(cop_matrix_size), 8'h02);
    req = 2'b00; req_op0 = 3'b010; req_size0 = 2'b01;  // late changes must not leak
    tick();                                   // RUN 1
    chk("t1_start", 8'(cop_start), 8'h01);
    chk("t1_state_run", 8'(dbg_state), 8'(ST_RUN));
    chk("t1_op_held", 8'(cop_op_code), 8'h01);
    tick();                                   // RUN 2
    chk("t1_start_pulse", 8'(cop_start), 8'h00);
    chk("t1_no_early_done", 8'(done), 8'h00);
    tick(); tick(); tick();                   // RUN 5
    cop_done = 1'b1;
    tick();                                   // COMPLETE
    cop_done = 1'b0;
    chk("t1_done",   8'(done), 8'h01);
    chk("t1_status", 8'(status), 8'h00);
    chk("t1_grant_at_done", 8'(grant), 8'h01);
    tick();                                   // IDLE
    chk("t1_release", 8'(grant), 8'h00);
    chk("t1_done_pulse", 8'(done), 8'h00);
    chk("t1_idle_busy", 8'(busy), 8'h00);
    chk("t1_op_kept",  8'(cop_op_code), 8'h01);
    chk("t1_size_kept", 8'(cop_matrix_size), 8'h02);
    chk("t1_err", err_cnt, 8'h00);

    // Both requesting from reset: strict alternation starting with 0.
    do_reset();
    req = 2'b11; req_op0 = 3'b001; req_size0 = 2'b00; req_op1 = 3'b010; req_size1 = 2'b11;
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    for (int k = 0; k < 4; k++) begin
      eg = exp_q.pop_front();
      tick();                                 // GRANT
      chk("rr_grant", 8'(grant), 8'(eg));
      chk("rr_op", 8'(cop_op_code), eg[1] ? 8'h02 : 8'h01);
      tick();                                 // RUN 1
      chk("rr_start", 8'(cop_start), 8'h01);
      cop_done = 1'b1;
      tick();                                 // COMPLETE
      cop_done = 1'b0;
      chk("rr_done", 8'(done), 8'(eg));
      tick();                                 // IDLE gap
      chk("rr_gap", 8'(grant), 8'h00);
    end
    req = 2'b00;

    // Watchdog expiry: no cop_done at all.
    req = 2'b01; req_op0 = 3'b011; req_size0 = 2'b01;
    tick();                                   // GRANT
    req = 2'b00;
    tick();                                   // RUN 1
    chk("to_start", 8'(cop_start), 8'h01);
    for (int i = 0; i < 15; i++) tick();      // RUN 16
    chk("to_still_run", 8'(dbg_state), 8'(ST_RUN));
    chk("to_no_done", 8'(done), 8'h00);
    tick();                                   // COMPLETE
    chk("to_done",   8'(done), 8'h01);
    chk("to_status", 8'(status), 8'h01);
    chk("to_err",    err_cnt, 8'h01);
    tick();
    chk("to_idle", 8'(busy), 8'h00);

    // Reserved opcode from requester 1.
    req = 2'b10; req_op1 = 3'b111;
    tick();                                   // GRANT
    chk("rsv_grant", 8'(grant), 8'h02);
    req = 2'b00;
    tick();                                   // COMPLETE
    chk("rsv_nostart", 8'(cop_start), 8'h00);
    chk("rsv_done",   8'(done), 8'h02);
    chk("rsv_status", 8'(status), 8'h02);
    chk("rsv_err",    err_cnt, 8'h02);
    tick();
    chk("rsv_done_pulse", 8'(done), 8'h00);

    // Reset on the 3rd RUN cycle.
    req = 2'b01; req_op0 = 3'b001;
    tick();                                   // GRANT
    req = 2'b00;
    tick(); tick(); tick();                   // RUN 3
    reset = 1'b1;
    tick();
    chk("mr_grant", 8'(grant), 8'h00);
    chk("mr_busy",  8'(busy), 8'h00);
    chk("mr_done",  8'(done), 8'h00);
    chk("mr_err",   err_cnt, 8'h00);
    chk("mr_state", 8'(dbg_state), 8'(ST_IDLE));
    reset = 1'b0;
    cop_done = 1'b1;
    tick();
    cop_done = 1'b0;
    chk("mr_late_done", 8'(done), 8'h00);
    chk("mr_late_busy", 8'(busy), 8'h00);
    chk("mr_late_start", 8'(cop_start), 8'h00);

    // Stray cop_done in IDLE, then a request dropped mid-RUN.
    cop_done = 1'b1;
    tick();
    cop_done = 1'b0;
    chk("idle_pulse_busy", 8'(busy), 8'h00);
    chk("idle_pulse_done", 8'(done), 8'h00);
    req = 2'b10; req_op1 = 3'b100; req_size1 = 2'b01;
    tick();                                   // GRANT
    chk("drop_grant", 8'(grant), 8'h02);
    tick();                                   // RUN 1
    req = 2'b00;
    tick(); tick();                           // RUN 3
    cop_done = 1'b1;
    tick();                                   // COMPLETE
    cop_done = 1'b0;
    chk("drop_done",   8'(done), 8'h02);
    chk("drop_status", 8'(status), 8'h00);
    chk("drop_op",     8'(cop_op_code), 8'h04);
    chk("drop_size",   8'(cop_matrix_size), 8'h01);
    tick();
    chk("drop_release", 8'(grant), 8'h00);
    chk("drop_err", err_cnt, 8'h00);

    // Error counter saturation via back-to-back rejects.
    req = 2'b01; req_op0 = 3'b111;
    for (int n = 0; n < 254; n++) begin
      tick(); tick(); tick();
    end
    chk("sat_254", err_cnt, 8'd254);
    for (int n = 0; n < 3; n++) begin
      tick(); tick(); tick();
    end
    chk("sat_255", err_cnt, 8'd255);
    req = 2'b00;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
